// File: rtl/y_bus_pkg.sv
// Shared constants, types and helpers for the Y-matrix update path.
package y_bus_pkg;

    localparam int Y_ADDR_W = 11;
    localparam int Y_ROW_W  = 256;
    localparam int Y_LANES  = 4;
    localparam int Y_VAL_W  = 48;
    localparam int Y_HALF_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_A,
        ST_WAIT_A,
        ST_ISSUE_B,
        ST_WAIT_B
    } ychg_state_e;

    typedef struct packed {
        logic [Y_ADDR_W-1:0] diag_addr;
        logic [Y_LANES-1:0]  diag_oh;
        logic [Y_ADDR_W-1:0] nond_addr;
        logic [Y_LANES-1:0]  nond_oh;
    } pass_t;

    // The most negative value has no positive twin; clamp it to the largest positive.
    function automatic logic [Y_HALF_W-1:0] y_sat_neg24(input logic [Y_HALF_W-1:0] x);
        logic [Y_HALF_W-1:0] min_val;
        min_val = {1'b1, {(Y_HALF_W-1){1'b0}}};
        if (x == min_val) begin
            return ~min_val;
        end
        return (~x) + Y_HALF_W'(1);
    endfunction

endpackage

// File: rtl/y_change_issue_if.sv
// Change-record input and row-update pass output bundle of y_change_issue.
interface y_change_issue_if
    import y_bus_pkg::*;
#(
    parameter int LOG2_NBUS = 6,
    parameter int CNT_W     = 16
);
    logic                 chg_valid;
    logic                 chg_ready;
    logic [LOG2_NBUS-1:0] chg_busI;
    logic [LOG2_NBUS-1:0] chg_busJ;
    logic [Y_VAL_W-1:0]   chg_data;
    logic                 chg_last;

    logic                 op_issueValid;
    logic [Y_ADDR_W-1:0]  op_diagAddr;
    logic [Y_ADDR_W-1:0]  op_nonDAddr;
    logic [Y_LANES-1:0]   op_diagOH;
    logic [Y_LANES-1:0]   op_nonDiagOH;
    logic [Y_ADDR_W-1:0]  op_yReadAddr1;
    logic [Y_ADDR_W-1:0]  op_yReadAddr2;
    logic [Y_VAL_W-1:0]   op_ychngData;
    logic [Y_VAL_W-1:0]   op_ychngNegData;
    logic                 in_writeDone;
    logic                 op_allDone;
    logic [CNT_W-1:0]     op_recCount;

    modport slave (
        input  chg_valid, chg_busI, chg_busJ, chg_data, chg_last, in_writeDone,
        output chg_ready, op_issueValid, op_diagAddr, op_nonDAddr, op_diagOH,
               op_nonDiagOH, op_yReadAddr1, op_yReadAddr2, op_ychngData,
               op_ychngNegData, op_allDone, op_recCount
    );

    modport master (
        output chg_valid, chg_busI, chg_busJ, chg_data, chg_last, in_writeDone,
        input  chg_ready, op_issueValid, op_diagAddr, op_nonDAddr, op_diagOH,
               op_nonDiagOH, op_yReadAddr1, op_yReadAddr2, op_ychngData,
               op_ychngNegData, op_allDone, op_recCount
    );

endinterface

// File: rtl/ychg_fifo2.sv
// Two-entry FIFO for change records; push is dropped when full, pop when empty.
module ychg_fifo2 #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/y_change_issue.sv
// Y-matrix change-record issue front-end: buffers (busI, busJ, y) records and
// issues a row-I pass, then a row-J pass, to the Y write stage.
//
// state    | meaning
// IDLE     | waiting for a buffered record
// ISSUE_A  | row-I pass fields valid, one-cycle issue pulse
// WAIT_A   | row-I pass held until writeDone
// ISSUE_B  | row-J pass fields valid, one-cycle issue pulse
// WAIT_B   | row-J pass held until writeDone
module y_change_issue
    import y_bus_pkg::*;
#(
    parameter int LOG2_NBUS = 6,
    parameter int CNT_W     = 16
) (
    input logic             clock,
    input logic             reset,
    y_change_issue_if.slave bus
);
    localparam int LIN_W = 2 * LOG2_NBUS;

    typedef struct packed {
        logic [LOG2_NBUS-1:0] bus_i;
        logic [LOG2_NBUS-1:0] bus_j;
        logic [Y_VAL_W-1:0]   data;
        logic                 last;
    } rec_t;

    function automatic logic [Y_ADDR_W-1:0] elem_row(input logic [LOG2_NBUS-1:0] r,
                                                     input logic [LOG2_NBUS-1:0] c);
        logic [LIN_W-1:0] lin;
        lin = {r, c};
        return Y_ADDR_W'(lin >> 2);
    endfunction

    function automatic logic [Y_LANES-1:0] elem_oh(input logic [LOG2_NBUS-1:0] c);
        return 4'b0001 << c[1:0];
    endfunction

    // Shunt records (r == c) carry no off-diagonal lane.
    function automatic pass_t make_pass(input logic [LOG2_NBUS-1:0] r,
                                        input logic [LOG2_NBUS-1:0] c);
        pass_t p;
        p.diag_addr = elem_row(r, r);
        p.diag_oh   = elem_oh(r);
        p.nond_addr = elem_row(r, c);
        p.nond_oh   = (r == c) ? '0 : elem_oh(c);
        return p;
    endfunction

    rec_t        fifo_wdata, fifo_head;
    logic        fifo_full, fifo_empty, fifo_pop, push_ok;
    logic [1:0]  fifo_count;

    ychg_state_e          state_q, state_d;
    logic [LOG2_NBUS-1:0] bus_i_q, bus_i_d, bus_j_q, bus_j_d;
    logic                 last_q, last_d;
    pass_t                pass_q, pass_d;
    logic                 issue_q, issue_d;
    logic [Y_VAL_W-1:0]   ydata_q, ydata_d, yneg_q, yneg_d;
    logic                 all_done_q, all_done_d;
    logic [CNT_W-1:0]     rec_cnt_q, rec_cnt_d;
    logic                 rec_done;

    assign push_ok    = bus.chg_valid && (fifo_count != 2'd2);
    assign fifo_wdata = '{bus_i: bus.chg_busI, bus_j: bus.chg_busJ,
                          data: bus.chg_data, last: bus.chg_last};

    ychg_fifo2 #(.W($bits(rec_t))) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_ok),
        .push_data(fifo_wdata),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        bus_i_d    = bus_i_q;
        bus_j_d    = bus_j_q;
        last_d     = last_q;
        pass_d     = pass_q;
        issue_d    = 1'b0;
        ydata_d    = ydata_q;
        yneg_d     = yneg_q;
        all_done_d = all_done_q;
        rec_cnt_d  = rec_cnt_q;
        fifo_pop   = 1'b0;
        rec_done   = 1'b0;

        if (push_ok) begin
            all_done_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    bus_i_d  = fifo_head.bus_i;
                    bus_j_d  = fifo_head.bus_j;
                    last_d   = fifo_head.last;
                    pass_d   = make_pass(fifo_head.bus_i, fifo_head.bus_j);
                    ydata_d  = fifo_head.data;
                    yneg_d   = {y_sat_neg24(fifo_head.data[47:24]),
                                y_sat_neg24(fifo_head.data[23:0])};
                    issue_d  = 1'b1;
                    state_d  = ST_ISSUE_A;
                end
            end
            ST_ISSUE_A: state_d = ST_WAIT_A;
            ST_WAIT_A: begin
                if (bus.in_writeDone) begin
                    if (bus_i_q == bus_j_q) begin
                        rec_done = 1'b1;
                    end else begin
                        pass_d  = make_pass(bus_j_q, bus_i_q);
                        issue_d = 1'b1;
                        state_d = ST_ISSUE_B;
                    end
                end
            end
            ST_ISSUE_B: state_d = ST_WAIT_B;
            ST_WAIT_B: begin
                if (bus.in_writeDone) begin
                    rec_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion outranks a same-cycle push clearing allDone.
        if (rec_done) begin
            rec_cnt_d = rec_cnt_q + CNT_W'(1);
            if (last_q) begin
                all_done_d = 1'b1;
            end
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bus_i_q    <= '0;
            bus_j_q    <= '0;
            last_q     <= 1'b0;
            pass_q     <= '0;
            issue_q    <= 1'b0;
            ydata_q    <= '0;
            yneg_q     <= '0;
            all_done_q <= 1'b0;
            rec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bus_i_q    <= bus_i_d;
            bus_j_q    <= bus_j_d;
            last_q     <= last_d;
            pass_q     <= pass_d;
            issue_q    <= issue_d;
            ydata_q    <= ydata_d;
            yneg_q     <= yneg_d;
            all_done_q <= all_done_d;
            rec_cnt_q  <= rec_cnt_d;
        end
    end

    assign bus.chg_ready       = !fifo_full;
    assign bus.op_issueValid   = issue_q;
    assign bus.op_diagAddr     = pass_q.diag_addr;
    assign bus.op_nonDAddr     = pass_q.nond_addr;
    assign bus.op_diagOH       = pass_q.diag_oh;
    assign bus.op_nonDiagOH    = pass_q.nond_oh;
    assign bus.op_yReadAddr1   = pass_q.diag_addr;
    assign bus.op_yReadAddr2   = pass_q.nond_addr;
    assign bus.op_ychngData    = ydata_q;
    assign bus.op_ychngNegData = yneg_q;
    assign bus.op_allDone      = all_done_q;
    assign bus.op_recCount     = rec_cnt_q;

endmodule

// File: tb/tb_y_change_issue.sv
// Self-checking bench for y_change_issue: vector table plus scoreboard of issued passes.
module tb_y_change_issue;
    import y_bus_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    y_change_issue_if #(.LOG2_NBUS(6), .CNT_W(16)) bus ();

    y_change_issue #(.LOG2_NBUS(6), .CNT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [10:0] diag;
        logic [3:0]  doh;
        logic [10:0] nond;
        logic [3:0]  noh;
        logic [47:0] ydata;
        logic [47:0] yneg;
    } exp_t;

    typedef struct {
        logic [5:0]  bi;
        logic [5:0]  bj;
        logic [47:0] data;
        logic        last;
        logic [10:0] a_diag;
        logic [3:0]  a_doh;
        logic [10:0] a_nond;
        logic [3:0]  a_noh;
        logic [10:0] b_diag;
        logic [3:0]  b_doh;
        logic [10:0] b_nond;
        logic [3:0]  b_noh;
        logic [47:0] neg;
    } vec_t;

    vec_t vecs [6];
    exp_t sb_q [$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   issues_seen = 0;
    int   passes_done = 0;
    int   exp_cnt     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout, expected DUT event", name);
    endtask

    always @(negedge clock) begin
        if (!reset && bus.op_issueValid) begin
            exp_t e;
            issues_seen++;
            if (sb_q.size() == 0) begin
                fail_now("unexpected_issue");
            end else begin
                e = sb_q.pop_front();
                check("diagAddr",   64'(bus.op_diagAddr),     64'(e.diag));
                check("diagOH",     64'(bus.op_diagOH),       64'(e.doh));
                check("nonDAddr",   64'(bus.op_nonDAddr),     64'(e.nond));
                check("nonDiagOH",  64'(bus.op_nonDiagOH),    64'(e.noh));
                check("yReadAddr1", 64'(bus.op_yReadAddr1),   64'(e.diag));
                check("yReadAddr2", 64'(bus.op_yReadAddr2),   64'(e.nond));
                check("ychngData",  64'(bus.op_ychngData),    64'(e.ydata));
                check("ychngNeg",   64'(bus.op_ychngNegData), 64'(e.yneg));
            end
        end
    end

    function automatic int npass(input int k);
        return (vecs[k].bi == vecs[k].bj) ? 1 : 2;
    endfunction

    // Call at a negedge; drives the record for one posedge once chg_ready is seen.
    task automatic push_vec(input int k);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (bus.chg_ready) begin
                bus.chg_valid = 1'b1;
                bus.chg_busI  = vecs[k].bi;
                bus.chg_busJ  = vecs[k].bj;
                bus.chg_data  = vecs[k].data;
                bus.chg_last  = vecs[k].last;
                e = '{vecs[k].a_diag, vecs[k].a_doh, vecs[k].a_nond, vecs[k].a_noh,
                      vecs[k].data, vecs[k].neg};
                sb_q.push_back(e);
                if (npass(k) == 2) begin
                    e = '{vecs[k].b_diag, vecs[k].b_doh, vecs[k].b_nond, vecs[k].b_noh,
                          vecs[k].data, vecs[k].neg};
                    sb_q.push_back(e);
                end
                @(negedge clock);
                bus.chg_valid = 1'b0;
                ok = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        if (!ok) fail_now("push_timeout");
    endtask

    // Returns at a negedge inside the WAIT state of the next unanswered pass.
    task automatic wait_issue();
        int t;
        t = 0;
        while (issues_seen <= passes_done && t < 60) begin
            @(negedge clock);
            t++;
        end
        if (issues_seen <= passes_done) fail_now("issue_timeout");
        if (bus.op_issueValid) @(negedge clock);
    endtask

    task automatic do_pass(input int dly);
        wait_issue();
        repeat (dly) @(negedge clock);
        bus.in_writeDone = 1'b1;
        @(negedge clock);
        bus.in_writeDone = 1'b0;
        passes_done++;
    endtask

    task automatic finish_rec(input int k, input string tag);
        for (int p = 0; p < npass(k); p++) do_pass(p);
        exp_cnt++;
        check({tag, "_recCount"}, 64'(bus.op_recCount), 64'(exp_cnt));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_issueValid"}, 64'(bus.op_issueValid),   64'(0));
        check({tag, "_diagAddr"},   64'(bus.op_diagAddr),     64'(0));
        check({tag, "_nonDAddr"},   64'(bus.op_nonDAddr),     64'(0));
        check({tag, "_diagOH"},     64'(bus.op_diagOH),       64'(0));
        check({tag, "_nonDiagOH"},  64'(bus.op_nonDiagOH),    64'(0));
        check({tag, "_yRead1"},     64'(bus.op_yReadAddr1),   64'(0));
        check({tag, "_yRead2"},     64'(bus.op_yReadAddr2),   64'(0));
        check({tag, "_ychngData"},  64'(bus.op_ychngData),    64'(0));
        check({tag, "_ychngNeg"},   64'(bus.op_ychngNegData), 64'(0));
        check({tag, "_allDone"},    64'(bus.op_allDone),      64'(0));
        check({tag, "_recCount"},   64'(bus.op_recCount),     64'(0));
        check({tag, "_chgReady"},   64'(bus.chg_ready),       64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        //            I      J      data                 last  A:diag  dOH      nond    nOH      B:diag  dOH      nond    nOH      neg
        vecs[0] = '{6'd3,  6'd5,  48'h000010_FFFFF0, 1'b0, 11'd48,   4'b1000, 11'd49,   4'b0010, 11'd81,  4'b0010, 11'd80,  4'b1000, 48'hFFFFF0_000010};
        vecs[1] = '{6'd7,  6'd7,  48'h000100_000000, 1'b0, 11'd113,  4'b1000, 11'd113,  4'b0000, 11'd0,   4'b0000, 11'd0,   4'b0000, 48'hFFFF00_000000};
        vecs[2] = '{6'd2,  6'd60, 48'h800000_000001, 1'b0, 11'd32,   4'b0100, 11'd47,   4'b0001, 11'd975, 4'b0001, 11'd960, 4'b0100, 48'h7FFFFF_FFFFFF};
        vecs[3] = '{6'd63, 6'd0,  48'h7FFFFF_FFFFFF, 1'b1, 11'd1023, 4'b1000, 11'd1008, 4'b0001, 11'd0,   4'b0001, 11'd15,  4'b1000, 48'h800001_000001};
        vecs[4] = '{6'd0,  6'd0,  48'h123456_000000, 1'b0, 11'd0,    4'b0001, 11'd0,    4'b0000, 11'd0,   4'b0000, 11'd0,   4'b0000, 48'hEDCBAA_000000};
        vecs[5] = '{6'd10, 6'd13, 48'hFFFFFE_800000, 1'b0, 11'd162,  4'b0100, 11'd163,  4'b0010, 11'd211, 4'b0010, 11'd210, 4'b0100, 48'h000002_7FFFFF};

        bus.chg_valid    = 1'b0;
        bus.chg_busI     = '0;
        bus.chg_busJ     = '0;
        bus.chg_data     = '0;
        bus.chg_last     = 1'b0;
        bus.in_writeDone = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check_zero("rst");
        reset = 1'b0;
        @(negedge clock);

        // Table: one record at a time, varying downstream write time.
        for (int k = 0; k < 6; k++) begin
            push_vec(k);
            check("allDone_cleared", 64'(bus.op_allDone), 64'(0));
            for (int p = 0; p < npass(k); p++) do_pass(k % 3 + p);
            exp_cnt++;
            check("tbl_recCount", 64'(bus.op_recCount), 64'(exp_cnt));
            check("tbl_allDone",  64'(bus.op_allDone),  64'(vecs[k].last));
        end

        // Backpressure: one in flight, two queued, fourth refused.
        push_vec(0);
        push_vec(2);
        push_vec(5);
        check("bp_ready_full", 64'(bus.chg_ready), 64'(0));
        bus.chg_valid = 1'b1;
        bus.chg_busI  = vecs[4].bi;
        bus.chg_busJ  = vecs[4].bj;
        bus.chg_data  = vecs[4].data;
        bus.chg_last  = vecs[4].last;
        repeat (3) begin
            @(negedge clock);
            check("bp_ready_refuse", 64'(bus.chg_ready), 64'(0));
        end
        bus.chg_valid = 1'b0;
        finish_rec(0, "bp0");
        finish_rec(2, "bp1");
        finish_rec(5, "bp2");
        repeat (5) @(negedge clock);
        check("bp_no_extra_issue", 64'(issues_seen), 64'(passes_done));
        check("bp_sb_empty",       64'(sb_q.size()), 64'(0));

        // Stray writeDone in IDLE, then across the pop and ISSUE_A cycles.
        bus.in_writeDone = 1'b1;
        repeat (3) @(negedge clock);
        bus.in_writeDone = 1'b0;
        check("stray_idle_cnt",   64'(bus.op_recCount), 64'(exp_cnt));
        check("stray_idle_issue", 64'(issues_seen),     64'(passes_done));
        push_vec(0);
        bus.in_writeDone = 1'b1;
        @(negedge clock);
        check("stray_in_issueA", 64'(bus.op_issueValid), 64'(1));
        @(negedge clock);
        bus.in_writeDone = 1'b0;
        repeat (3) @(negedge clock);
        check("stray_issueA_issues", 64'(issues_seen),     64'(passes_done + 1));
        check("stray_issueA_cnt",    64'(bus.op_recCount), 64'(exp_cnt));
        finish_rec(0, "stray");

        // chg_last on the second of two records.
        push_vec(0);
        push_vec(3);
        finish_rec(0, "last0");
        check("last_first_allDone", 64'(bus.op_allDone), 64'(0));
        for (int p = 0; p < 2; p++) begin
            do_pass(1);
            if (p == 0) check("last_mid_allDone", 64'(bus.op_allDone), 64'(0));
        end
        exp_cnt++;
        check("last_recCount", 64'(bus.op_recCount), 64'(exp_cnt));
        check("last_allDone",  64'(bus.op_allDone),  64'(1));

        // Async reset in WAIT_B with one record queued.
        push_vec(5);
        push_vec(2);
        do_pass(0);
        wait_issue();
        #2 reset = 1'b1;
        #1;
        check_zero("arst");
        sb_q.delete();
        issues_seen = 0;
        passes_done = 0;
        exp_cnt     = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("arst_no_replay", 64'(issues_seen), 64'(0));
        push_vec(1);
        finish_rec(1, "arst_new");
        check("arst_allDone", 64'(bus.op_allDone), 64'(0));

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
